out_video_timing_ctrl: RTL and testbench



---
 rtl/out_video_timing_ctrl.sv | 152 +++++++++++++++
 tb/tb_out_video_timing_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/out_video_timing_ctrl.sv
// Output video timing controller: raw VSYNC/HSYNC/DE, coordinates and
// line/frame markers for one programmable frame format.
//
// Ports:
//   CLK          pixel clock, rising edge
//   RST_N        synchronous active-low reset
//   iENABLE      run request; sampled in RUN only at the frame-end cycle
//   oRUNNING     controller is in RUN
//   oVSYNC       raw vertical sync, active high
//   oHSYNC       raw horizontal sync, active high
//   oDE          data enable, high in the active area
//   oX / oY      counter values of the current output cycle
//   oLINE_START  pulse at h=0 of every line
//   oFRAME_START pulse at h=0, v=0
module out_video_timing_ctrl #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CNT_WIDTH = 12
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 iENABLE,
  output logic                 oRUNNING,
  output logic                 oVSYNC,
  output logic                 oHSYNC,
  output logic                 oDE,
  output logic [CNT_WIDTH-1:0] oX,
  output logic [CNT_WIDTH-1:0] oY,
  output logic                 oLINE_START,
  output logic                 oFRAME_START
);

  localparam int W = CNT_WIDTH;

  localparam logic [W-1:0] H_ACT = W'(H_ACTIVE);
  localparam logic [W-1:0] H_S0  = W'(H_ACTIVE + H_FP);
  localparam logic [W-1:0] H_S1  = W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [W-1:0] H_END =
    W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);

  localparam logic [W-1:0] V_ACT = W'(V_ACTIVE);
  localparam logic [W-1:0] V_S0  = W'(V_ACTIVE + V_FP);
  localparam logic [W-1:0] V_S1  = W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [W-1:0] V_END =
    W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [W-1:0] h_q, h_d;
  logic [W-1:0] v_q, v_d;

  logic         vs_q, vs_d;
  logic         hs_q, hs_d;
  logic         de_q, de_d;
  logic         ls_q, ls_d;
  logic         fs_q, fs_d;
  logic [W-1:0] x_q, x_d;
  logic [W-1:0] y_q, y_d;

  logic h_last;
  logic v_last;
  logic run;

  assign h_last = (h_q == H_END);
  assign v_last = (v_q == V_END);
  assign run    = (state_q == ST_RUN);

  // Next state and counters
  always_comb begin
    state_d = state_q;
    h_d     = '0;
    v_d     = '0;
    if (run) begin
      h_d = h_last ? '0 : h_q + W'(1);
      v_d = v_q;
      if (h_last) begin
        v_d = v_last ? '0 : v_q + W'(1);
      end
      // Enable is only honoured at the frame end, so a
      // frame is never cut short by a stop request.
      if (h_last && v_last && !iENABLE) begin
        state_d = ST_IDLE;
      end
    end else if (iENABLE) begin
      state_d = ST_RUN;
    end
  end

  // Region decode; everything reads 0 while idle
  always_comb begin
    de_d = 1'b0;
    hs_d = 1'b0;
    vs_d = 1'b0;
    ls_d = 1'b0;
    fs_d = 1'b0;
    x_d  = '0;
    y_d  = '0;
    if (run) begin
      de_d = (h_q < H_ACT) && (v_q < V_ACT);
      hs_d = (h_q >= H_S0) && (h_q < H_S1);
      vs_d = (v_q >= V_S0) && (v_q < V_S1);
      ls_d = (h_q == '0);
      fs_d = (h_q == '0) && (v_q == '0);
      x_d  = h_q;
      y_d  = v_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      v_q     <= '0;
      vs_q    <= 1'b0;
      hs_q    <= 1'b0;
      de_q    <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      vs_q    <= vs_d;
      hs_q    <= hs_d;
      de_q    <= de_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign oRUNNING     = run;
  assign oVSYNC       = vs_q;
  assign oHSYNC       = hs_q;
  assign oDE          = de_q;
  assign oX           = x_q;
  assign oY           = y_q;
  assign oLINE_START  = ls_q;
  assign oFRAME_START = fs_q;

endmodule

// File: tb/tb_out_video_timing_ctrl.sv
// Testbench for out_video_timing_ctrl on an 8x6 frame format.
// Frame-position model checked every cycle plus directed checks.
module tb_out_video_timing_ctrl;

  localparam int HA = 4, HF = 1, HSW = 2, HB = 1;
  localparam int VA = 3, VF = 1, VSW = 1, VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FT = HT * VT;
  localparam int W  = 12;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         running, vs, hs, de, ls, fs;
  logic [W-1:0] ox, oy;

  int tests = 0;
  int fails = 0;

  out_video_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .CNT_WIDTH(W)
  ) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .iENABLE(en),
    .oRUNNING(running),
    .oVSYNC(vs),
    .oHSYNC(hs),
    .oDE(de),
    .oX(ox),
    .oY(oy),
    .oLINE_START(ls),
    .oFRAME_START(fs)
  );

  always #5 clk = ~clk;

  // Model: position inside the frame (0..FT-1) and run flag.
  // Output of a position derives from the region rules.
  bit         m_run = 1'b0;
  int         m_pos = 0;
  bit         started = 1'b0;
  logic [29:0] exp_v = '0;

  function automatic logic [29:0] pix(input int p);
    int x, y;
    logic e_de, e_hs, e_vs;
    x = p % HT;
    y = p / HT;
    e_de = (x < HA) && (y < VA);
    e_hs = (x >= HA + HF) && (x < HA + HF + HSW);
    e_vs = (y >= VA + VF) && (y < VA + VF + VSW);
    return {1'b0, e_vs, e_hs, e_de, (x == 0), (p == 0),
            W'(x), W'(y)};
  endfunction

  always @(posedge clk) begin
    logic [29:0] nv;
    started <= 1'b1;
    nv = '0;
    if (!rst_n) begin
      m_run = 1'b0;
      m_pos = 0;
    end else if (!m_run) begin
      if (en) begin
        m_run = 1'b1;
        m_pos = 0;
      end
    end else begin
      nv = pix(m_pos);
      if (m_pos == FT - 1) begin
        m_pos = 0;
        if (!en) m_run = 1'b0;
      end else begin
        m_pos = m_pos + 1;
      end
    end
    nv[29] = m_run;
    exp_v = nv;
  end

  wire [29:0] act_v = {running, vs, hs, de, ls, fs, ox, oy};

  always @(negedge clk) begin
    if (started) begin
      tests++;
      if (act_v !== exp_v) begin
        fails++;
        $display("FAIL model t=%0t got %h want %h",
                 $time, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string name, input int got,
                     input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Step until oFRAME_START, returning number of steps taken
  task automatic wait_fs(output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!fs && n < 200);
    if (!fs) chk("fs_timeout", 0, 1);
  endtask

  initial begin
    int n, dec, vsc, vfirst, vlast, vbad, fsc;
    // Reset and idle
    step(3);
    chk("rst_out", int'(act_v), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("idle_out", int'(act_v), 0);
    end

    // Start and first line
    en = 1'b1;
    step(1);
    chk("start_running", int'(running), 1);
    chk("start_no_fs", int'(fs), 0);
    for (int i = 0; i < HT; i++) begin
      step(1);
      chk("line_x", int'(ox), i);
      chk("line_y", int'(oy), 0);
      chk("line_de", int'(de), int'(i < 4));
      chk("line_hs", int'(hs), int'(i == 5 || i == 6));
      chk("line_ls", int'(ls), int'(i == 0));
      chk("line_fs", int'(fs), int'(i == 0));
    end

    // Full frame statistics
    wait_fs(n);
    chk("fs_gap_first", n, 41);
    dec = 0; vsc = 0; vbad = 0; fsc = 0;
    vfirst = -1; vlast = -1;
    for (int c = 0; c < 48; c++) begin
      if (de) dec++;
      if (fs) fsc++;
      if (vs) begin
        vsc++;
        if (vfirst < 0) vfirst = c;
        vlast = c;
        if (oy != 4) vbad++;
      end
      step(1);
    end
    chk("frame_fs_period", int'(fs), 1);
    chk("frame_de_count", dec, 12);
    chk("frame_vs_count", vsc, 8);
    chk("frame_vs_span", vlast - vfirst, 7);
    chk("frame_vs_y4", vbad, 0);
    chk("frame_fs_count", fsc, 1);

    // Mid-frame stop at y=1
    step(8);
    chk("stop_at_y", int'(oy), 1);
    en = 1'b0;
    n = 0;
    while (!(ox == 7 && oy == 5) && n < 100) begin
      step(1);
      n++;
    end
    chk("stop_last_px", n, 39);
    step(1);
    chk("stop_zero", int'(act_v), 0);
    fsc = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (fs) fsc++;
      if (running) fsc++;
    end
    chk("stop_no_restart", fsc, 0);

    // Restart, then cancelled stop
    en = 1'b1;
    wait_fs(n);
    chk("restart_lat", n, 2);
    step(16);
    chk("cancel_y2", int'(oy), 2);
    en = 1'b0;
    step(16);
    chk("cancel_y4", int'(oy), 4);
    en = 1'b1;
    wait_fs(n);
    chk("cancel_gap", n, 16);

    // Reset mid-operation at y=2, x=3
    step(19);
    chk("mrst_x", int'(ox), 3);
    chk("mrst_y", int'(oy), 2);
    rst_n = 1'b0;
    step(1);
    chk("mrst_zero", int'(act_v), 0);
    rst_n = 1'b1;
    step(1);
    chk("mrst_run", int'(running), 1);
    chk("mrst_nofs", int'(fs), 0);
    step(1);
    chk("mrst_fs", int'(fs), 1);
    chk("mrst_x0", int'(ox), 0);
    chk("mrst_y0", int'(oy), 0);
    chk("mrst_de", int'(de), 1);
    step(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
